// File: rtl/fft_result_reader.sv
// fft_result_reader: drains the FFT result RAM in natural bin order and
// streams each bin (real, imag, |re|+|im|, index, last) on a valid/ready port.
// A two-entry FIFO absorbs the one-cycle RAM read latency so that a stalled
// consumer never loses data and a ready consumer sees one beat per cycle.
module fft_result_reader #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_real,
    input  logic [DATA_WIDTH-1:0] rd_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_real,
    output logic [DATA_WIDTH-1:0] out_imag,
    output logic [DATA_WIDTH:0]   out_mag,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned N         = 2 ** ADDR_WIDTH;
    localparam int unsigned MAG_WIDTH = DATA_WIDTH + 1;
    localparam int unsigned CNT_WIDTH = 2;
    localparam int unsigned OCC_WIDTH = 3;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One FIFO entry: a bin as it will be presented on the output port.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] re;
        logic [DATA_WIDTH-1:0] im;
        logic [MAG_WIDTH-1:0]  mag;
    } beat_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  inflight_q, inflight_d;
    beat_t                 fifo_q [2];
    beat_t                 fifo_d [2];
    logic                  wr_sel_q, wr_sel_d;
    logic                  rd_sel_q, rd_sel_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic                  done_q, done_d;

    logic                  pop;
    logic                  push;
    logic                  start_accept;
    logic                  room;
    logic [OCC_WIDTH-1:0]  occupancy;
    logic [MAG_WIDTH-1:0]  new_mag;
    beat_t                 head;

    // Absolute value of a sign-extended word; the most negative input maps
    // to 2**(DATA_WIDTH-1) without saturating.
    function automatic logic [MAG_WIDTH-1:0] abs_ext(input logic [DATA_WIDTH-1:0] v);
        logic [MAG_WIDTH-1:0] e;
        e = {v[DATA_WIDTH-1], v};
        return e[MAG_WIDTH-1] ? MAG_WIDTH'(-e) : e;
    endfunction

    // Handshake and occupancy terms shared by the FSM and datapath.
    always_comb begin
        head         = fifo_q[rd_sel_q];
        pop          = (count_q != '0) && out_ready;
        push         = inflight_q;
        start_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        occupancy    = OCC_WIDTH'(count_q) + OCC_WIDTH'(inflight_q) - OCC_WIDTH'(pop);
        room         = occupancy < OCC_WIDTH'(2);
        new_mag      = abs_ext(rd_real) + abs_ext(rd_imag);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (room && (ptr_q == LAST_ADDR)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && (index_q == LAST_ADDR)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: read strobe and busy flag decoded from state.
    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        case (state_q)
            S_READ: begin
                rd_en = room;
                busy  = 1'b1;
            end
            S_DRAIN: begin
                busy  = 1'b1;
            end
            default: begin
                rd_en = 1'b0;
                busy  = 1'b0;
            end
        endcase
    end

    // Datapath next values: issue pointer, in-flight flag, FIFO, index, done.
    always_comb begin
        ptr_d      = ptr_q;
        inflight_d = rd_en;
        fifo_d     = fifo_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        count_d    = count_q;
        index_d    = index_q;
        done_d     = done_q;

        if (start_accept) begin
            ptr_d = '0;
        end else if (rd_en) begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
        end

        if (push) begin
            fifo_d[wr_sel_q] = '{re: rd_real, im: rd_imag, mag: new_mag};
            wr_sel_d         = ~wr_sel_q;
        end
        if (pop) begin
            rd_sel_d = ~rd_sel_q;
        end
        count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);

        if (start_accept) begin
            index_d = '0;
        end else if (pop && (index_q != LAST_ADDR)) begin
            index_d = index_q + ADDR_WIDTH'(1);
        end

        if (start_accept) begin
            done_d = 1'b0;
        end else if (pop && (index_q == LAST_ADDR)) begin
            done_d = 1'b1;
        end
    end

    // Datapath registers; reset discards any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            count_q    <= '0;
            index_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            count_q    <= count_d;
            index_q    <= index_d;
            done_q     <= done_d;
        end
    end

    // Output port mapping from the FIFO head and status registers.
    always_comb begin
        rd_addr   = ptr_q;
        out_valid = (count_q != '0);
        out_real  = head.re;
        out_imag  = head.im;
        out_mag   = head.mag;
        out_index = index_q;
        out_last  = out_valid && (index_q == LAST_ADDR);
        done      = done_q;
    end

endmodule

// File: tb/tb_fft_result_reader.sv
// Bench for fft_result_reader: RAM model, scoreboard of expected beats
// pushed on each read issue and checked on each output transfer.
module tb_fft_result_reader;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 16;
    localparam int unsigned N  = 32;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [DW:0]   mag;
        logic [AW-1:0] idx;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_real;
    logic [DW-1:0] rd_imag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_real;
    logic [DW-1:0] out_imag;
    logic [DW:0]   out_mag;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] ram_re [N];
    logic [DW-1:0] ram_im [N];
    logic [DW:0]   mag_log [N];
    exp_t          sb [$];
    int            n_assert = 0;
    int            n_fail   = 0;
    int            beats    = 0;
    bit            prev_stall = 1'b0;
    exp_t          prev_beat;

    fft_result_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_real(rd_real), .rd_imag(rd_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag), .out_mag(out_mag),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_real <= ram_re[rd_addr];
            rd_imag <= ram_im[rd_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int a);
        exp_t e;
        int   r;
        int   i;
        r      = int'($signed(ram_re[a]));
        i      = int'($signed(ram_im[a]));
        e.re   = ram_re[a];
        e.im   = ram_im[a];
        e.mag  = (DW+1)'((r < 0 ? -r : r) + (i < 0 ? -i : i));
        e.idx  = AW'(a);
        e.last = (a == int'(N) - 1);
        return e;
    endfunction

    // Monitor: hold check while stalled, scoreboard on transfer, read bound.
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        got = {out_real, out_imag, out_mag, out_index, out_last};
        if (reset) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold", 64'({out_valid, got}), 64'({1'b1, prev_beat}));
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    want = sb.pop_front();
                    chk("beat", 64'(got), 64'(want));
                end
                mag_log[out_index] = out_mag;
                beats++;
            end
            if (rd_en) begin
                sb.push_back(model(int'(rd_addr)));
            end
            if (busy) begin
                chk("outstanding", 64'(sb.size() <= 2), 64'(1));
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = got;
        end
    end

    function automatic logic rdy(input int mode, input int k);
        return (mode == 0) ? 1'b1 : ((k % 3) == 0);
    endfunction

    task automatic check_zero(input string tag);
        chk(tag, {rd_en, rd_addr, out_valid, out_real, out_imag, out_mag,
                  out_index, out_last, busy, done}, 64'(0));
    endtask

    // Runs one frame; cycle 0 is the cycle after the edge that sees start.
    task automatic run_frame(input int mode, input int restart,
                             output int first_v, output int last_c, output int done_c,
                             output logic [AW:0] first_rd);
        first_v  = -1;
        last_c   = -1;
        done_c   = -1;
        first_rd = '0;
        @(posedge clk);
        #1;
        beats     = 0;
        start     = 1'b1;
        out_ready = rdy(mode, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k == 0) first_rd = {rd_en, rd_addr};
            if (out_valid && first_v < 0) first_v = k;
            if (out_valid && out_ready && out_last) last_c = k;
            if (done) begin
                done_c = k;
                chk("busy_at_done", 64'(busy), 64'(0));
                break;
            end
            @(posedge clk);
            #1;
            out_ready = rdy(mode, k + 1);
            start     = (k + 1 == restart);
        end
        start = 1'b0;
        chk("frame_timeout", 64'(done_c >= 0), 64'(1));
    endtask

    task automatic check_full_rate(input string tag, input int fv, input int lc, input int dc,
                                   input logic [AW:0] frd);
        chk({tag, "_first_rd"}, 64'(frd), 64'({1'b1, AW'(0)}));
        chk({tag, "_first_valid"}, 64'(fv), 64'(2));
        chk({tag, "_last_cycle"}, 64'(lc), 64'(N + 1));
        chk({tag, "_done_cycle"}, 64'(dc), 64'(N + 2));
        chk({tag, "_beats"}, 64'(beats), 64'(N));
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        int            fv;
        int            lc;
        int            dc;
        logic [AW:0]   frd;

        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            ram_re[k] = DW'(k);
            ram_im[k] = DW'(-k);
        end
        #3;
        check_zero("reset_outputs");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_zero("idle_outputs");

        // Full-rate frame, ready held high.
        run_frame(0, -1, fv, lc, dc, frd);
        check_full_rate("frame1", fv, lc, dc, frd);
        chk("frame1_mag31", 64'(mag_log[31]), 64'(62));

        // Start from DONE: second frame must be identical.
        chk("done_level", 64'(done), 64'(1));
        run_frame(0, -1, fv, lc, dc, frd);
        check_full_rate("frame2", fv, lc, dc, frd);

        // Ready 1-of-3: no loss or duplication, done right after last beat.
        run_frame(1, -1, fv, lc, dc, frd);
        chk("stall_beats", 64'(beats), 64'(N));
        chk("stall_done_after_last", 64'(dc), 64'(lc + 1));
        chk("stall_sb_empty", 64'(sb.size()), 64'(0));

        // Start pulsed mid-frame is ignored.
        run_frame(0, 10, fv, lc, dc, frd);
        check_full_rate("restart_ignored", fv, lc, dc, frd);

        // Magnitude corner cases.
        ram_re[0] = 16'h8000;
        ram_im[0] = 16'h8000;
        ram_re[1] = 16'hfc01;
        ram_im[1] = 16'h03ff;
        run_frame(0, -1, fv, lc, dc, frd);
        check_full_rate("mag_frame", fv, lc, dc, frd);
        chk("mag_most_negative", 64'(mag_log[0]), 64'(65536));
        chk("mag_mixed", 64'(mag_log[1]), 64'(2046));

        // Reset while beat 12 is stalled, then a fresh frame.
        @(posedge clk);
        #1;
        beats     = 0;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid && out_ready && out_index == AW'(11)) break;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("stalled_index", 64'({out_valid, out_index}), 64'({1'b1, AW'(12)}));
        #2;
        reset = 1'b1;
        #1;
        check_zero("mid_frame_reset");
        @(posedge clk);
        @(negedge clk);
        check_zero("reset_held");
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_frame(0, -1, fv, lc, dc, frd);
        check_full_rate("after_reset", fv, lc, dc, frd);
        chk("after_reset_mag0", 64'(mag_log[0]), 64'(65536));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
